// File: rtl/pu_riscv_biu_arb.sv
// -----------------------------------------------------------------------------
// pu_riscv_biu_arb
//   Arbitrates two CPU bus-interface masters onto a single BIU slave (the
//   BIU-to-Wishbone bridge).
//   Port 0 is ibiu (instruction fetch) and port 1 is dbiu (load/store).
//   dbiu has priority, but only for STARVE_MAX consecutive grants while ibiu
//   waits. A granted burst owns the bus until its last beat or an error.
//   A locked owner keeps the bus (HOLD) until it drops both lock and strobe.
//
// Ports
//   HCLK, HRESET              clock, asynchronous active-high reset
//   ibiu_* / dbiu_*           master request inputs (stb, adri, size, type,
//                             prot, lock, we, d); responses (stb_ack, d_ack,
//                             adro, q, ack, err)
//   biu_*                     slave request outputs and slave responses
// -----------------------------------------------------------------------------
module pu_riscv_biu_arb #(
    parameter int XLEN       = 64,
    parameter int PLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            HCLK,
    input  logic            HRESET,

    input  logic            ibiu_stb_i,
    input  logic [PLEN-1:0] ibiu_adri_i,
    input  logic [2:0]      ibiu_size_i,
    input  logic [2:0]      ibiu_type_i,
    input  logic [2:0]      ibiu_prot_i,
    input  logic            ibiu_lock_i,
    input  logic            ibiu_we_i,
    input  logic [XLEN-1:0] ibiu_d_i,
    output logic            ibiu_stb_ack_o,
    output logic            ibiu_d_ack_o,
    output logic [PLEN-1:0] ibiu_adro_o,
    output logic [XLEN-1:0] ibiu_q_o,
    output logic            ibiu_ack_o,
    output logic            ibiu_err_o,

    input  logic            dbiu_stb_i,
    input  logic [PLEN-1:0] dbiu_adri_i,
    input  logic [2:0]      dbiu_size_i,
    input  logic [2:0]      dbiu_type_i,
    input  logic [2:0]      dbiu_prot_i,
    input  logic            dbiu_lock_i,
    input  logic            dbiu_we_i,
    input  logic [XLEN-1:0] dbiu_d_i,
    output logic            dbiu_stb_ack_o,
    output logic            dbiu_d_ack_o,
    output logic [PLEN-1:0] dbiu_adro_o,
    output logic [XLEN-1:0] dbiu_q_o,
    output logic            dbiu_ack_o,
    output logic            dbiu_err_o,

    output logic            biu_stb_o,
    output logic [PLEN-1:0] biu_adri_o,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    input  logic [PLEN-1:0] biu_adro_i,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i
);

    // state | meaning
    // IDLE  | no burst; combinational winner drives the slave
    // BUSY  | burst accepted, counting data beats for owner
    // HOLD  | locked owner keeps the bus between bursts

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    // Burst type encodings of the BIU interface
    localparam logic [2:0] SINGLE = 3'd0, INCR  = 3'd1, WRAP4  = 3'd2, INCR4  = 3'd3,
                           WRAP8  = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic [4:0]  beats, beats_nxt;
    logic [2:0]  starve, starve_nxt;

    logic        win_valid, win_sel, sel;
    logic        sel_stb, sel_lock;
    logic [2:0]  sel_type;
    logic        fwd_stb, rt_stb_ack, rt_d_ack, rt_ack, rt_err;

    function automatic logic [4:0] burst_beats(input logic [2:0] btype);
        case (btype)
            SINGLE, INCR:   burst_beats = 5'd1;
            WRAP4,  INCR4:  burst_beats = 5'd4;
            WRAP8,  INCR8:  burst_beats = 5'd8;
            WRAP16, INCR16: burst_beats = 5'd16;
            default:        burst_beats = 5'd1;
        endcase
    endfunction

    // dbiu wins unless ibiu is waiting and has been passed over STARVE_MAX times
    assign win_valid = ibiu_stb_i | dbiu_stb_i;
    assign win_sel   = dbiu_stb_i & ~(ibiu_stb_i & (starve == STARVE_LIM));

    // Outside IDLE the registered owner steers both request and response paths
    assign sel      = (state == IDLE) ? win_sel : owner;
    assign sel_stb  = sel ? dbiu_stb_i  : ibiu_stb_i;
    assign sel_lock = sel ? dbiu_lock_i : ibiu_lock_i;
    assign sel_type = sel ? dbiu_type_i : ibiu_type_i;

    assign biu_adri_o = sel ? dbiu_adri_i : ibiu_adri_i;
    assign biu_size_o = sel ? dbiu_size_i : ibiu_size_i;
    assign biu_type_o = sel_type;
    assign biu_prot_o = sel ? dbiu_prot_i : ibiu_prot_i;
    assign biu_lock_o = sel_lock;
    assign biu_we_o   = sel ? dbiu_we_i   : ibiu_we_i;
    assign biu_d_o    = sel ? dbiu_d_i    : ibiu_d_i;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= IDLE;
            owner  <= 1'b0;
            beats  <= 5'd0;
            starve <= 3'd0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            beats  <= beats_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        beats_nxt  = beats;
        starve_nxt = starve;
        fwd_stb    = 1'b0;
        rt_stb_ack = 1'b0;
        rt_d_ack   = 1'b0;
        rt_ack     = 1'b0;
        rt_err     = 1'b0;

        case (state)
            IDLE: begin
                // slave ack/err without an accepted burst are dropped here
                fwd_stb    = win_valid;
                rt_stb_ack = win_valid & biu_stb_ack_i;
                rt_d_ack   = win_valid & biu_d_ack_i;
                if (win_valid && biu_stb_ack_i) begin
                    state_nxt = BUSY;
                    owner_nxt = win_sel;
                    beats_nxt = burst_beats(sel_type);
                    if (!win_sel)
                        starve_nxt = 3'd0;
                    else if (ibiu_stb_i && starve != STARVE_LIM)
                        starve_nxt = starve + 3'd1;
                end
            end

            BUSY: begin
                rt_stb_ack = biu_stb_ack_i;
                rt_d_ack   = biu_d_ack_i;
                rt_err     = biu_err_i;
                rt_ack     = biu_ack_i & ~biu_err_i;
                if (biu_err_i) begin
                    beats_nxt = 5'd0;
                    state_nxt = sel_lock ? HOLD : IDLE;
                end else if (biu_ack_i) begin
                    beats_nxt = beats - 5'd1;
                    if (beats == 5'd1)
                        state_nxt = sel_lock ? HOLD : IDLE;
                end
            end

            HOLD: begin
                fwd_stb    = sel_stb;
                rt_stb_ack = sel_stb & biu_stb_ack_i;
                rt_d_ack   = biu_d_ack_i;
                if (sel_stb && biu_stb_ack_i) begin
                    state_nxt = BUSY;
                    beats_nxt = burst_beats(sel_type);
                end else if (!sel_lock && !sel_stb) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Reset masks the combinational strobe and every response to the masters
    assign biu_stb_o      = fwd_stb & ~HRESET;
    assign ibiu_stb_ack_o = rt_stb_ack & ~sel & ~HRESET;
    assign dbiu_stb_ack_o = rt_stb_ack &  sel & ~HRESET;
    assign ibiu_d_ack_o   = rt_d_ack   & ~sel & ~HRESET;
    assign dbiu_d_ack_o   = rt_d_ack   &  sel & ~HRESET;
    assign ibiu_ack_o     = rt_ack     & ~sel & ~HRESET;
    assign dbiu_ack_o     = rt_ack     &  sel & ~HRESET;
    assign ibiu_err_o     = rt_err     & ~sel & ~HRESET;
    assign dbiu_err_o     = rt_err     &  sel & ~HRESET;

    assign ibiu_q_o    = biu_q_i;
    assign dbiu_q_o    = biu_q_i;
    assign ibiu_adro_o = biu_adro_i;
    assign dbiu_adro_o = biu_adro_i;

endmodule

// File: tb/tb_pu_riscv_biu_arb.sv
module tb_pu_riscv_biu_arb;

    localparam int XLEN = 64, PLEN = 64, STARVE_MAX = 4;

    logic HCLK = 1'b0;
    logic HRESET;

    logic            ibiu_stb_i, ibiu_lock_i, ibiu_we_i;
    logic [PLEN-1:0] ibiu_adri_i;
    logic [2:0]      ibiu_size_i, ibiu_type_i, ibiu_prot_i;
    logic [XLEN-1:0] ibiu_d_i;
    logic            ibiu_stb_ack_o, ibiu_d_ack_o, ibiu_ack_o, ibiu_err_o;
    logic [PLEN-1:0] ibiu_adro_o;
    logic [XLEN-1:0] ibiu_q_o;

    logic            dbiu_stb_i, dbiu_lock_i, dbiu_we_i;
    logic [PLEN-1:0] dbiu_adri_i;
    logic [2:0]      dbiu_size_i, dbiu_type_i, dbiu_prot_i;
    logic [XLEN-1:0] dbiu_d_i;
    logic            dbiu_stb_ack_o, dbiu_d_ack_o, dbiu_ack_o, dbiu_err_o;
    logic [PLEN-1:0] dbiu_adro_o;
    logic [XLEN-1:0] dbiu_q_o;

    logic            biu_stb_o, biu_lock_o, biu_we_o;
    logic [PLEN-1:0] biu_adri_o;
    logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
    logic [XLEN-1:0] biu_d_o;
    logic            biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;
    logic [PLEN-1:0] biu_adro_i;
    logic [XLEN-1:0] biu_q_i;

    pu_riscv_biu_arb #(.XLEN(XLEN), .PLEN(PLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .ibiu_stb_i(ibiu_stb_i), .ibiu_adri_i(ibiu_adri_i), .ibiu_size_i(ibiu_size_i),
        .ibiu_type_i(ibiu_type_i), .ibiu_prot_i(ibiu_prot_i), .ibiu_lock_i(ibiu_lock_i),
        .ibiu_we_i(ibiu_we_i), .ibiu_d_i(ibiu_d_i), .ibiu_stb_ack_o(ibiu_stb_ack_o),
        .ibiu_d_ack_o(ibiu_d_ack_o), .ibiu_adro_o(ibiu_adro_o), .ibiu_q_o(ibiu_q_o),
        .ibiu_ack_o(ibiu_ack_o), .ibiu_err_o(ibiu_err_o),
        .dbiu_stb_i(dbiu_stb_i), .dbiu_adri_i(dbiu_adri_i), .dbiu_size_i(dbiu_size_i),
        .dbiu_type_i(dbiu_type_i), .dbiu_prot_i(dbiu_prot_i), .dbiu_lock_i(dbiu_lock_i),
        .dbiu_we_i(dbiu_we_i), .dbiu_d_i(dbiu_d_i), .dbiu_stb_ack_o(dbiu_stb_ack_o),
        .dbiu_d_ack_o(dbiu_d_ack_o), .dbiu_adro_o(dbiu_adro_o), .dbiu_q_o(dbiu_q_o),
        .dbiu_ack_o(dbiu_ack_o), .dbiu_err_o(dbiu_err_o),
        .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
        .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_d_ack_i(biu_d_ack_i), .biu_adro_i(biu_adro_i), .biu_q_i(biu_q_i),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: starve count and burst length per type code
    int m_starve;
    int len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    function automatic int pick();
        if (dbiu_stb_i && !(ibiu_stb_i && m_starve == STARVE_MAX)) return 1;
        if (ibiu_stb_i) return 0;
        return -1;
    endfunction

    function automatic logic [255:0] req_fields(input int p);
        if (p == 1)
            return {117'd0, dbiu_adri_i, dbiu_size_i, dbiu_type_i, dbiu_prot_i,
                    dbiu_lock_i, dbiu_we_i, dbiu_d_i};
        return {117'd0, ibiu_adri_i, ibiu_size_i, ibiu_type_i, ibiu_prot_i,
                ibiu_lock_i, ibiu_we_i, ibiu_d_i};
    endfunction

    task automatic new_req(input int p, input logic [2:0] t, input logic lk);
        if (p == 0) begin
            ibiu_stb_i  = 1'b1;           ibiu_type_i = t;
            ibiu_adri_i = {$urandom, $urandom};
            ibiu_size_i = 3'($urandom);   ibiu_prot_i = 3'($urandom);
            ibiu_lock_i = lk;             ibiu_we_i   = 1'b0;
            ibiu_d_i    = {$urandom, $urandom};
        end else begin
            dbiu_stb_i  = 1'b1;           dbiu_type_i = t;
            dbiu_adri_i = {$urandom, $urandom};
            dbiu_size_i = 3'($urandom);   dbiu_prot_i = 3'($urandom);
            dbiu_lock_i = lk;             dbiu_we_i   = 1'($urandom);
            dbiu_d_i    = {$urandom, $urandom};
        end
    endtask

    // Called a moment after a rising edge with the request(s) already set.
    // Grants one burst to exp_o, then delivers nb beats (err on beat err_b).
    task automatic do_burst(input int exp_o, input int nb, input int err_b,
                            input bit upd, input bit drop, output int got);
        logic [255:0] f;
        bit e;
        #1;
        chk("grant_stb", biu_stb_o, 1'b1);
        f = req_fields(exp_o);
        chk("idle_fields", {117'd0, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o,
                            biu_lock_o, biu_we_o, biu_d_o}, f);
        biu_stb_ack_i = 1'b1;
        #1;
        got = dbiu_stb_ack_o ? 1 : (ibiu_stb_ack_o ? 0 : -1);
        chk("grant_i", ibiu_stb_ack_o, exp_o == 0);
        chk("grant_d", dbiu_stb_ack_o, exp_o == 1);
        if (upd) begin
            if (exp_o == 0) m_starve = 0;
            else if (ibiu_stb_i && m_starve < STARVE_MAX) m_starve++;
        end
        cyc();
        biu_stb_ack_i = 1'b0;
        chk("beats_load", dut.beats, nb);
        if (drop) begin
            if (exp_o == 1) dbiu_stb_i = 1'b0; else ibiu_stb_i = 1'b0;
        end
        for (int b = 1; b <= nb; b++) begin
            e = (b == err_b);
            biu_err_i   = e;
            biu_ack_i   = e ? 1'($urandom_range(0, 1)) : 1'b1;
            biu_d_ack_i = 1'($urandom_range(0, 1));
            biu_q_i     = {$urandom, $urandom};
            biu_adro_i  = {$urandom, $urandom};
            #1;
            chk("busy_stb", biu_stb_o, 1'b0);
            chk("busy_fields", {117'd0, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o,
                                biu_lock_o, biu_we_o, biu_d_o}, f);
            chk("own_ack", exp_o ? dbiu_ack_o : ibiu_ack_o, !e);
            chk("own_err", exp_o ? dbiu_err_o : ibiu_err_o, e);
            chk("own_d_ack", exp_o ? dbiu_d_ack_o : ibiu_d_ack_o, biu_d_ack_i);
            chk("other_resp", exp_o ? {ibiu_ack_o, ibiu_err_o, ibiu_d_ack_o}
                                    : {dbiu_ack_o, dbiu_err_o, dbiu_d_ack_o}, 3'b000);
            chk("bcast", {ibiu_q_o, dbiu_q_o, ibiu_adro_o, dbiu_adro_o},
                         {biu_q_i, biu_q_i, biu_adro_i, biu_adro_i});
            cyc();
            biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_d_ack_i = 1'b0;
            if (e) begin
                chk("err_beats", dut.beats, 0);
                break;
            end
        end
    endtask

    initial begin
        int got, ex, nb, eb;
        int order_exp [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        HRESET = 1'b1;
        ibiu_stb_i = 0; ibiu_adri_i = '0; ibiu_size_i = 0; ibiu_type_i = 0; ibiu_prot_i = 0;
        ibiu_lock_i = 0; ibiu_we_i = 0; ibiu_d_i = '0;
        dbiu_stb_i = 0; dbiu_adri_i = '0; dbiu_size_i = 0; dbiu_type_i = 0; dbiu_prot_i = 0;
        dbiu_lock_i = 0; dbiu_we_i = 0; dbiu_d_i = '0;
        biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_ack_i = 0; biu_err_i = 0;
        biu_adro_i = '0; biu_q_i = '0;
        m_starve = 0;

        // Reset: outputs held low even with requests and slave responses active
        #1;
        new_req(0, 3'd0, 1'b0); new_req(1, 3'd0, 1'b0);
        biu_stb_ack_i = 1; biu_ack_i = 1; biu_err_i = 1; biu_d_ack_i = 1;
        #1;
        chk("rst_stb", biu_stb_o, 1'b0);
        chk("rst_resp", {ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_ack_o, dbiu_ack_o,
                         ibiu_err_o, dbiu_err_o, ibiu_d_ack_o, dbiu_d_ack_o}, 8'h00);
        cyc(); cyc();
        biu_stb_ack_i = 0; biu_ack_i = 0; biu_err_i = 0; biu_d_ack_i = 0;
        HRESET = 1'b0;

        // Both SINGLE: dbiu first, then ibiu; grant in first cycle after reset
        do_burst(pick(), 1, 0, 1, 1, got);
        chk("first_d", got, 1);
        do_burst(pick(), 1, 0, 1, 1, got);
        chk("then_i", got, 0);

        // ack/err in IDLE are ignored
        biu_ack_i = 1; biu_err_i = 1;
        #1;
        chk("idle_ack_ign", {ibiu_ack_o, dbiu_ack_o, ibiu_err_o, dbiu_err_o, biu_stb_o}, 5'd0);
        cyc();
        biu_ack_i = 0; biu_err_i = 0;

        // dbiu INCR8 alone
        new_req(1, 3'd5, 1'b0);
        biu_ack_i = 1;
        #1;
        chk("idle_ack_req", dbiu_ack_o, 1'b0);
        biu_ack_i = 0;
        ex = pick();
        do_burst(ex, len_tab[dbiu_type_i], 0, 1, 1, got);
        chk("incr8_owner", got, 1);

        // Starvation order with both requesting continuously
        new_req(0, 3'd0, 1'b0); new_req(1, 3'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ex = pick();
            do_burst(ex, 1, 0, 1, 0, got);
            chk("order", got, order_exp[k]);
        end

        // WRAP4 error on beat 2; other master next
        new_req(0, 3'd0, 1'b0); new_req(1, 3'd2, 1'b0);
        do_burst(pick(), 4, 2, 1, 1, got);
        chk("wrap4_owner", got, 1);
        biu_err_i = 1; biu_ack_i = 1;
        #1;
        chk("err_one_cycle", {dbiu_err_o, ibiu_err_o, dbiu_ack_o, ibiu_ack_o}, 4'd0);
        biu_err_i = 0; biu_ack_i = 0;
        do_burst(pick(), 1, 0, 1, 1, got);
        chk("after_err_i", got, 0);

        // Locked dbiu keeps the bus across two SINGLE writes
        new_req(0, 3'd0, 1'b0); new_req(1, 3'd0, 1'b1); dbiu_we_i = 1'b1;
        do_burst(pick(), 1, 0, 1, 0, got);
        chk("lock_first", got, 1);
        new_req(1, 3'd0, 1'b1); dbiu_we_i = 1'b1;
        do_burst(1, 1, 0, 0, 0, got);
        dbiu_stb_i = 0; biu_stb_ack_i = 1;
        #1;
        chk("hold_no_fwd", biu_stb_o, 1'b0);
        chk("hold_no_i", ibiu_stb_ack_o, 1'b0);
        cyc();
        biu_stb_ack_i = 0; dbiu_lock_i = 0;
        #1;
        chk("hold_exit_cyc", biu_stb_o, 1'b0);
        cyc();
        do_burst(pick(), 1, 0, 1, 1, got);
        chk("unlock_i", got, 0);

        // Reset during beat 5 of INCR16
        ibiu_stb_i = 0;
        new_req(1, 3'd7, 1'b0);
        #1;
        biu_stb_ack_i = 1;
        cyc();
        biu_stb_ack_i = 0; dbiu_stb_i = 0;
        for (int b = 1; b <= 4; b++) begin
            biu_ack_i = 1;
            cyc();
            biu_ack_i = 0;
        end
        biu_ack_i = 1; dbiu_stb_i = 1; biu_stb_ack_i = 1;
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_mid_stb", biu_stb_o, 1'b0);
        chk("rst_mid_resp", {ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_ack_o, dbiu_ack_o,
                             ibiu_err_o, dbiu_err_o, ibiu_d_ack_o, dbiu_d_ack_o}, 8'h00);
        chk("rst_mid_beats", dut.beats, 0);
        biu_ack_i = 0; biu_stb_ack_i = 0;
        cyc(); cyc();
        HRESET = 1'b0;
        m_starve = 0;
        new_req(1, 3'd0, 1'b0);
        do_burst(pick(), 1, 0, 1, 1, got);
        chk("post_rst_d", got, 1);

        // Randomized traffic against the model
        ibiu_stb_i = 0; dbiu_stb_i = 0;
        for (int n = 0; n < 40; n++) begin
            if (!ibiu_stb_i && $urandom_range(0, 1)) new_req(0, 3'($urandom), 1'b0);
            if (!dbiu_stb_i && $urandom_range(0, 1)) new_req(1, 3'($urandom), 1'b0);
            if (!ibiu_stb_i && !dbiu_stb_i) new_req($urandom_range(0, 1), 3'($urandom), 1'b0);
            ex = pick();
            nb = len_tab[(ex == 1) ? dbiu_type_i : ibiu_type_i];
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : 0;
            do_burst(ex, nb, eb, 1, 1, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
